// File: rtl/aoi_lane_pipe.sv
// Per-lane AND-OR(-invert) evaluator behind an elastic valid/ready pipeline of
// STAGES register slices, with a saturating count of delivered output beats.
module aoi_lane_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    input  logic [WIDTH-1:0] in_e,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_mode,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] beat_cnt
);

    logic [WIDTH-1:0] f_in;
    logic [WIDTH-1:0] y_in;

    assign f_in = (in_a & in_c & in_d) | (in_e & ~in_b);
    assign y_in = in_mode ? f_in : ~f_in;

    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] mode_reg;
    logic [WIDTH-1:0]  data_reg [STAGES];

    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_mode;
    logic [WIDTH-1:0]  up_data  [STAGES];

    // ready[k]: stage k may load this cycle (empty, or its beat moves on).
    logic [STAGES:0]   ready;

    assign ready[STAGES] = out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            assign ready[gi] = ~valid_reg[gi] | ready[gi+1];

            if (gi == 0) begin : g_src_in
                assign up_valid[gi] = in_valid;
                assign up_mode[gi]  = in_mode;
                assign up_data[gi]  = y_in;
            end else begin : g_src_prev
                assign up_valid[gi] = valid_reg[gi-1];
                assign up_mode[gi]  = mode_reg[gi-1];
                assign up_data[gi]  = data_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    mode_reg[gi]  <= 1'b0;
                    data_reg[gi]  <= '0;
                end else if (ready[gi]) begin
                    valid_reg[gi] <= up_valid[gi];
                    // Payload only moves with a real beat so bubbles never disturb it.
                    if (up_valid[gi]) begin
                        mode_reg[gi] <= up_mode[gi];
                        data_reg[gi] <= up_data[gi];
                    end
                end
            end
        end
    endgenerate

    // Outputs are forced quiet for the whole reset window, including its first cycle.
    assign in_ready  = ready[0] & ~rst;
    assign out_valid = valid_reg[STAGES-1] & ~rst;
    assign out_mode  = mode_reg[STAGES-1] & ~rst;
    assign out_y     = rst ? '0 : data_reg[STAGES-1];

    logic             out_hs;
    logic [CNT_W-1:0] beat_cnt_reg;

    assign out_hs = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            beat_cnt_reg <= '0;
        end else if (out_hs && (beat_cnt_reg != {CNT_W{1'b1}})) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        end
    end

    assign beat_cnt = rst ? '0 : beat_cnt_reg;

endmodule

// File: tb/tb_aoi_lane_pipe.sv
// Scoreboard bench: directed checks on a STAGES=2/CNT_W=4 instance plus
// randomized traffic on instances with STAGES = 1..4.
module tb_aoi_lane_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=beat expected=none", name);
    endtask

    // Reference: per lane, f = a&c&d | e&~b; mode 0 returns the inverse.
    function automatic logic [7:0] ref_y(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d,
                                         input logic [7:0] e, input logic mode);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) begin
            logic f;
            f = (a[i] && c[i] && d[i]) || (e[i] && !b[i]);
            y[i] = mode ? f : !f;
        end
        return y;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- main instance ----------------
    logic       rst, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, clr_cnt;
    logic [7:0] in_a, in_b, in_c, in_d, in_e, out_y;
    logic [3:0] beat_cnt;

    aoi_lane_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_mode(out_mode),
        .clr_cnt(clr_cnt), .beat_cnt(beat_cnt)
    );

    logic [8:0] exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("main_unexpected_beat");
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("main_sb_y", 64'(out_y), 64'(e[8:1]));
                    check("main_sb_mode", 64'(out_mode), 64'(e[0]));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({ref_y(in_a, in_b, in_c, in_d, in_e, in_mode), in_mode});
        end
    end

    task automatic set_beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] e, input logic mode);
        in_a = a; in_b = b; in_c = c; in_d = d; in_e = e; in_mode = mode;
    endtask

    task automatic set_random_beat;
        set_beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)));
    endtask

    // ---------------- STAGES sweep instances ----------------
    genvar gi;
    generate
        for (gi = 1; gi <= 4; gi++) begin : g_sweep
            logic        s_rst, s_in_valid, s_in_ready, s_in_mode;
            logic        s_out_valid, s_out_ready, s_out_mode, s_clr;
            logic [7:0]  s_a, s_b, s_c, s_d, s_e, s_out_y;
            logic [15:0] s_cnt;
            logic [8:0]  q[$];
            int          n_in  = 0;
            int          n_out = 0;
            bit          done  = 1'b0;

            aoi_lane_pipe #(.WIDTH(8), .STAGES(gi), .CNT_W(16)) u_sweep (
                .clk(clk), .rst(s_rst),
                .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mode(s_in_mode),
                .in_a(s_a), .in_b(s_b), .in_c(s_c), .in_d(s_d), .in_e(s_e),
                .out_valid(s_out_valid), .out_ready(s_out_ready), .out_y(s_out_y),
                .out_mode(s_out_mode), .clr_cnt(s_clr), .beat_cnt(s_cnt)
            );

            always @(negedge clk) begin
                if (!s_rst) begin
                    if (s_out_valid && s_out_ready) begin
                        n_out++;
                        if (q.size() == 0) begin
                            fail_now($sformatf("sweep%0d_unexpected_beat", gi));
                        end else begin
                            logic [8:0] e;
                            e = q.pop_front();
                            check($sformatf("sweep%0d_y", gi), 64'(s_out_y), 64'(e[8:1]));
                            check($sformatf("sweep%0d_mode", gi), 64'(s_out_mode), 64'(e[0]));
                        end
                    end
                    if (s_in_valid && s_in_ready) begin
                        n_in++;
                        q.push_back({ref_y(s_a, s_b, s_c, s_d, s_e, s_in_mode), s_in_mode});
                    end
                end
            end

            initial begin
                s_rst = 1'b1; s_in_valid = 1'b0; s_in_mode = 1'b0; s_out_ready = 1'b0;
                s_clr = 1'b0; s_a = '0; s_b = '0; s_c = '0; s_d = '0; s_e = '0;
                repeat (2) @(posedge clk);
                #1 s_rst = 1'b0;
                for (int t = 0; t < 300; t++) begin
                    s_in_valid  = 1'($urandom_range(0, 1));
                    s_out_ready = ($urandom_range(0, 3) != 0);
                    s_in_mode   = 1'($urandom_range(0, 1));
                    s_a = 8'($urandom); s_b = 8'($urandom); s_c = 8'($urandom);
                    s_d = 8'($urandom); s_e = 8'($urandom);
                    tick();
                end
                s_in_valid  = 1'b0;
                s_out_ready = 1'b1;
                for (int t = 0; t < 50 && q.size() != 0; t++) tick();
                tick();
                @(negedge clk);
                check($sformatf("sweep%0d_drained", gi), 64'(q.size()), 64'd0);
                check($sformatf("sweep%0d_hs_equal", gi), 64'(n_out), 64'(n_in));
                check($sformatf("sweep%0d_beat_cnt", gi), 64'(s_cnt), 64'(n_out));
                done = 1'b1;
            end
        end
    endgenerate

    // ---------------- directed sequence ----------------
    logic [7:0] ra[4], rb[4], rc[4], rd[4], re[4];
    logic       rm[4];
    logic [7:0] y_hold;
    int         idx;
    int         seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        set_beat('0, '0, '0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
        check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // Single AOI beat and its latency.
        tick();
        out_ready = 1'b1;
        set_beat(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        check("aoi_accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("aoi_not_early", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("aoi_valid_n2", 64'(out_valid), 64'd1);
        check("aoi_y", 64'(out_y), 64'h00);
        tick();
        @(negedge clk);
        check("aoi_beat_cnt", 64'(beat_cnt), 64'd1);

        // AO mode then a mode change on the very next beat.
        set_beat(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b1);
        in_valid = 1'b1;
        tick();
        set_beat(8'h00, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("ao_y", 64'(out_y), 64'hFF);
        check("ao_mode", 64'(out_mode), 64'd1);
        tick();
        @(negedge clk);
        check("mix_y", 64'(out_y), 64'h0F);
        check("mix_mode", 64'(out_mode), 64'd0);
        tick();

        // Backpressure: only STAGES beats fit, output holds steady.
        for (int i = 0; i < 4; i++) begin
            ra[i] = 8'($urandom); rb[i] = 8'($urandom); rc[i] = 8'($urandom);
            rd[i] = 8'($urandom); re[i] = 8'($urandom); rm[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            set_beat(ra[idx], rb[idx], rc[idx], rd[idx], re[idx], rm[idx]);
            in_valid = 1'b1;
            @(negedge clk);
            if (cyc == 2) y_hold = out_y;
            if (cyc > 2) begin
                check("stall_y_stable", 64'(out_y), 64'(y_hold));
                check("stall_valid_held", 64'(out_valid), 64'd1);
            end
            if (in_ready) idx++;
            tick();
        end
        check("stall_accepted", 64'(idx), 64'd2);
        set_beat(ra[idx], rb[idx], rc[idx], rd[idx], re[idx], rm[idx]);
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b1;
        for (int t = 0; t < 20 && idx < 4; t++) begin
            set_beat(ra[idx], rb[idx], rc[idx], rd[idx], re[idx], rm[idx]);
            @(negedge clk);
            if (in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        check("release_accepted", 64'(idx), 64'd4);
        repeat (4) tick();
        @(negedge clk);
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Counter clear, saturation, and clear-over-handshake priority.
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        @(negedge clk);
        check("cnt_cleared", 64'(beat_cnt), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_random_beat();
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("cnt_saturate", 64'(beat_cnt), 64'd15);
        set_random_beat();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clr_cnt = 1'b1;
        @(negedge clk);
        check("clr_hs_present", 64'(out_valid && out_ready), 64'd1);
        tick();
        clr_cnt = 1'b0;
        @(negedge clk);
        check("clr_priority", 64'(beat_cnt), 64'd0);

        // Reset with beats in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_random_beat();
        tick();
        set_random_beat();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("midrst_valid_next", 64'(out_valid), 64'd0);
        check("midrst_beat_cnt", 64'(beat_cnt), 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (out_valid) seen++;
            tick();
        end
        check("no_stale_beat", 64'(seen), 64'd0);

        for (int t = 0; t < 2000 && !(g_sweep[1].done && g_sweep[2].done &&
                                      g_sweep[3].done && g_sweep[4].done); t++)
            @(posedge clk);
        check("sweep_finished", 64'(g_sweep[1].done && g_sweep[2].done &&
                                    g_sweep[3].done && g_sweep[4].done), 64'd1);
        check("main_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aoi_lane_pipe.md
AOI_LANE_PIPE -- requirements
Module: aoi_lane_pipe

Interface
REQ-001 Parameter WIDTH, default 8: number of independent bit lanes evaluated per beat (legal range 1..64).
REQ-002 Parameter STAGES, default 2: register stages between input acceptance and output (legal range 1..4).
REQ-003 Parameter CNT_W, default 16: width of the delivered-beat counter.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  an input beat is presented.
REQ-008 in_ready  out  1  the block accepts the beat this cycle.
REQ-009 in_mode  in  1  0 = inverted (AOI) result, 1 = non-inverted (AO) result.
REQ-010 in_a, in_b, in_c, in_d, in_e  in  WIDTH each  per-lane operands.
REQ-011 out_valid  out  1  an output beat is presented.
REQ-012 out_ready  in  1  the consumer accepts the beat this cycle.
REQ-013 out_y  out  WIDTH  per-lane result.
REQ-014 out_mode  out  1  the in_mode value that travelled with this beat.
REQ-015 clr_cnt  in  1  synchronous clear of beat_cnt.
REQ-016 beat_cnt  out  CNT_W  count of completed output handshakes.

Function
REQ-017 Per lane i: f[i] = (in_a[i] & in_c[i] & in_d[i]) | (in_e[i] & ~in_b[i]); y[i] = ~f[i] when mode = 0, else y[i] = f[i].
REQ-018 An input handshake occurs when in_valid & in_ready; an output handshake occurs when out_valid & out_ready.
REQ-019 The result, mode and a valid flag travel through STAGES registered stages; the final stage drives out_y, out_mode and out_valid.
REQ-020 With out_ready held high, a beat accepted in cycle N appears with out_valid = 1 in cycle N+STAGES; sustained throughput is one beat per cycle.
REQ-021 A stage loads when it is empty or its contents move downstream in the same cycle; an empty (bubble) stage fills without waiting on out_ready.
REQ-022 in_ready = first stage empty, or first stage advancing this cycle; in_ready has no combinational path from in_valid.
REQ-023 While out_valid = 1 and out_ready = 0, out_y and out_mode hold stable and out_valid stays 1.
REQ-024 Under backpressure the block holds at most STAGES beats, with no loss, duplication or reordering.
REQ-025 beat_cnt increments by 1 on each output handshake and saturates at 2^CNT_W-1 without wrapping.
REQ-026 clr_cnt = 1 sets beat_cnt to 0 in the next cycle and takes priority over a simultaneous handshake.
REQ-027 in_mode is sampled per beat; changing mode between consecutive beats affects only the beat it is presented with.

Reset
REQ-028 While rst = 1: all stage valid flags clear, out_valid = 0, out_y = 0, out_mode = 0, beat_cnt = 0, in_ready = 0.
REQ-029 In the first cycle after rst deasserts, in_ready = 1.
REQ-030 Reset asserted mid-stream discards all in-flight beats; none appears at the output afterwards.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-031 Mode 0; a=FF, b=00, c=FF, d=FF, e=00, out_ready=1; accepted in cycle N -> out_y=00 with out_valid=1 in cycle N+2, and beat_cnt=1 one cycle later.
REQ-032 Same operands with mode 1 -> out_y=FF, out_mode=1; operands a=00, b=0F, e=FF, mode 0 -> out_y=0F.
REQ-033 Hold out_ready=0 and offer 4 back-to-back beats -> exactly 2 beats accepted, then in_ready=0 and out_y stable; release out_ready -> beats emerge in order, then the remaining 2 are accepted.
REQ-034 CNT_W=4, 17 output handshakes -> beat_cnt=15; clr_cnt asserted together with a handshake -> beat_cnt=0.
REQ-035 Assert rst with 2 beats in flight -> out_valid=0 and beat_cnt=0 next cycle; no stale beat appears after release.
REQ-036 Random in_valid/out_ready, STAGES swept 1..4 -> scoreboard matches REQ-017 for every beat, with handshake counts equal at drain.
